gate_share_arbiter: RTL and testbench
=====================================

Name: gate_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one W-bit bitwise logic-gate unit among N_REQ requesters.
- The unit performs NAND, AND, NOR or OR, selected per request.
- Each requester uses a valid/ready handshake on its request. Results return on a single shared response channel, tagged with the requester index.
- Sits between lab stimulus sources and the gate datapath so that a single gate instance serves all clients.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- W, 8, operand/result width in bits
- ID_W, 2, width of resp_id; must equal clog2(N_REQ)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  N_REQ  per-requester request valid
- req_ready  output  N_REQ  one-hot grant/accept; high for exactly one cycle when that request is taken
- req_a  input  N_REQ*W  operand A, requester i at bits [i*W +: W]
- req_b  input  N_REQ*W  operand B, same packing
- req_op  input  N_REQ*2  op code, requester i at [i*2 +: 2]: 00 NAND, 01 AND, 10 NOR, 11 OR
- resp_valid  output  1  result valid
- resp_ready  input  1  downstream accepts result
- resp_y  output  W  result word
- resp_id  output  ID_W  index of the requester that owns resp_y
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, resp_valid=0, resp_y=0, resp_id=0, busy=0.
  - Latched operands cleared.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any req_valid is high, select the first i with req_valid[i]=1, searching cyclically from rr_ptr upward and wrapping N_REQ-1 -> 0.
  - req_ready[i] is driven combinationally in this cycle. The transfer occurs at this edge.
  - Latch a, b, op and id=i; set rr_ptr=(i+1) mod N_REQ; go to EXEC.
  - If no request is valid, stay in IDLE and keep rr_ptr unchanged.
- EXEC (1 cycle):
  - Compute a bitwise op on the latched operands: NAND = ~(a&b), AND = a&b, NOR = ~(a|b), OR = a|b.
  - Register the result into resp_y and id into resp_id; go to RESP.
- RESP:
  - resp_valid=1; resp_y and resp_id are held stable until resp_valid && resp_ready at a posedge.
  - On that edge, resp_valid=0 and the FSM goes to IDLE.
  - resp_ready is ignored outside RESP.
- Latency: grant edge to resp_valid high is 2 clocks. Minimum request-to-request spacing is 3 clocks when resp_ready is held high.
- req_ready is 0 in EXEC and RESP; new requests wait there, and their operands are not sampled.
- Requesters must hold req_valid, req_a, req_b and req_op stable until req_ready. A request that deasserts before its grant is simply dropped; no error.
- Simultaneous requests: exactly one grant per IDLE cycle, chosen round-robin. No requester is starved; any valid requester is granted within N_REQ transactions.
- rr_ptr wraps mod N_REQ. Non-power-of-2 N_REQ is supported; pointer values >= N_REQ never occur.
- Reset mid-operation: rst in EXEC or RESP aborts the transaction with no response issued. All outputs return to reset values on that edge.
- A resp_ready held low keeps the block in RESP indefinitely; busy stays 1.

Optional Feature:
- Macro GATE_SHARE_ARBITER_STATS_EN.
- Defined:
  - Adds output op_count (16 bits) and output grant_hist (N_REQ*8 bits).
  - op_count increments on each completed response handshake and saturates at 16'hFFFF.
  - grant_hist holds one 8-bit saturating grant counter per requester, incremented on each grant.
  - Both are cleared by rst.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset check: rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, resp_valid=0, resp_y=0, busy=0; first grant after reset goes to requester 0.
- Single request: req0 a=8'hF0, b=8'hCC, op=00 (NAND), resp_ready=1 -> req_ready[0] at cycle 0; resp_valid at cycle 2 with resp_y=8'h3F and resp_id=0; busy low at cycle 3.
- Op coverage: requester 2 with a=8'hA5, b=8'h0F -> op 01 gives 8'h05, op 10 gives 8'h50, op 11 gives 8'hAF, op 00 gives 8'hFA.
- Round-robin fairness: all 4 req_valid held high, resp_ready=1, 8 transactions -> grant order 0,1,2,3,0,1,2,3; resp_id follows the same order.
- Backpressure: resp_ready=0 for 5 cycles during RESP -> resp_y and resp_id stable, req_ready stays 0 for all requesters; resp_ready=1 -> exactly one response transfer, then IDLE and the next grant.
- Reset mid-operation: assert rst in EXEC -> no resp_valid pulse, rr_ptr=0, next grant goes to the lowest valid index. With GATE_SHARE_ARBITER_STATS_EN defined, op_count and grant_hist also read 0.

Source files
------------

// File: rtl/gate_share_arbiter_if.sv
// gate_share_arbiter_if: request/response bundle for the shared gate unit.
// Requester i occupies req_a/req_b[i*W +: W] and req_op[i*2 +: 2].
interface gate_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int ID_W  = 2
) ();

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ*2-1:0] req_op;
  logic               resp_valid;
  logic               resp_ready;
  logic [W-1:0]       resp_y;
  logic [ID_W-1:0]    resp_id;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output req_op,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_y,
    input  resp_id
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_op,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_y,
    output resp_id
  );

endinterface

// File: rtl/gate_share_arbiter.sv
// gate_share_arbiter: round-robin sharing of one NAND/AND/NOR/OR unit.
// Optional counters op_count/grant_hist: GATE_SHARE_ARBITER_STATS_EN.
module gate_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  gate_share_arbiter_if.slave  bus,
  output logic                 busy
`ifdef GATE_SHARE_ARBITER_STATS_EN
  ,
  output logic [15:0]          op_count,
  output logic [N_REQ*8-1:0]   grant_hist
`endif
);

  typedef enum logic [1:0] {
    OP_NAND = 2'b00,
    OP_AND  = 2'b01,
    OP_NOR  = 2'b10,
    OP_OR   = 2'b11
  } gate_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    gate_op_t        op;
    logic [ID_W-1:0] id;
  } job_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  job_t            job;
  logic            resp_valid_q;
  logic [W-1:0]    resp_y_q;
  logic [ID_W-1:0] resp_id_q;

  logic [W-1:0]    a_arr  [N_REQ];
  logic [W-1:0]    b_arr  [N_REQ];
  logic [1:0]      op_arr [N_REQ];

  logic            sel_found;
  logic [ID_W-1:0] sel_idx;
  logic [ID_W-1:0] cand;
  int              cand_int;
  logic [ID_W-1:0] next_ptr;
  logic [N_REQ-1:0] grant;
  logic [W-1:0]    gate_y;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i]  = bus.req_a[i*W +: W];
    assign b_arr[i]  = bus.req_b[i*W +: W];
    assign op_arr[i] = bus.req_op[i*2 +: 2];
  end

  // Cyclic search for the first valid requester starting at rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_int  = 0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_int = int'(rr_ptr) + k;
      if (cand_int >= N_REQ)
        cand_int = cand_int - N_REQ;
      cand = ID_W'(cand_int);
      if (!sel_found && bus.req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Pointer moves just past the winner, wrapping at N_REQ.
  always_comb begin
    next_ptr = '0;
    if (sel_idx != ID_W'(N_REQ - 1))
      next_ptr = sel_idx + 1'b1;
  end

  // One-hot accept, only while idle and out of reset.
  always_comb begin
    grant = '0;
    if (!rst && state == S_IDLE && sel_found)
      grant[sel_idx] = 1'b1;
  end

  // The shared gate unit working on the latched operands.
  always_comb begin
    gate_y = '0;
    unique case (job.op)
      OP_NAND: gate_y = ~(job.a & job.b);
      OP_AND:  gate_y = job.a & job.b;
      OP_NOR:  gate_y = ~(job.a | job.b);
      OP_OR:   gate_y = job.a | job.b;
      default: gate_y = '0;
    endcase
  end

  // Sequencer: grant/latch, execute, hold response until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      job          <= '0;
      resp_valid_q <= 1'b0;
      resp_y_q     <= '0;
      resp_id_q    <= '0;
      busy         <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (sel_found) begin
            job.a  <= a_arr[sel_idx];
            job.b  <= b_arr[sel_idx];
            job.op <= gate_op_t'(op_arr[sel_idx]);
            job.id <= sel_idx;
            rr_ptr <= next_ptr;
            busy   <= 1'b1;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          resp_y_q     <= gate_y;
          resp_id_q    <= job.id;
          resp_valid_q <= 1'b1;
          state        <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = grant;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_y     = resp_y_q;
  assign bus.resp_id    = resp_id_q;

`ifdef GATE_SHARE_ARBITER_STATS_EN
  logic resp_fire;
  assign resp_fire = (state == S_RESP) && bus.resp_ready;

  // Saturating counters of completed responses and per-requester grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count   <= '0;
      grant_hist <= '0;
    end else begin
      if (resp_fire && op_count != 16'hFFFF)
        op_count <= op_count + 16'd1;
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i] && grant_hist[i*8 +: 8] != 8'hFF)
          grant_hist[i*8 +: 8] <= grant_hist[i*8 +: 8] + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gate_share_arbiter.sv
// tb_gate_share_arbiter: directed and random checks of the shared gate.
// Expected results come from a cyclic-pick model and a gate truth table.
module tb_gate_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  gate_share_arbiter_if #(.N_REQ(N), .W(W), .ID_W(IW)) bus ();

`ifdef GATE_SHARE_ARBITER_STATS_EN
  logic [15:0]      op_count;
  logic [N*8-1:0]   grant_hist;
`endif

  gate_share_arbiter #(.N_REQ(N), .W(W), .ID_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy)
`ifdef GATE_SHARE_ARBITER_STATS_EN
    ,
    .op_count   (op_count),
    .grant_hist (grant_hist)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] v;
  logic [7:0] ra  [N];
  logic [7:0] rb  [N];
  logic [1:0] rop [N];
  int         ptr;
  int         m_ops;
  int         m_gr [N];

  function automatic logic [7:0] gate(input logic [1:0] op,
                                      input logic [7:0] a,
                                      input logic [7:0] b);
    case (op)
      2'd0:    return ~(a & b);
      2'd1:    return a & b;
      2'd2:    return ~(a | b);
      default: return a | b;
    endcase
  endfunction

  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (m[j[1:0]]) return j;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    bus.req_valid = v;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = ra[i];
      bus.req_b[i*W +: W] = rb[i];
      bus.req_op[i*2 +: 2] = rop[i];
    end
  endtask

  task automatic scramble();
    bus.req_a      = $urandom;
    bus.req_b      = $urandom;
    bus.req_op     = 8'($urandom);
    bus.resp_ready = 1'($urandom);
  endtask

  task automatic clear_model();
    ptr   = 0;
    m_ops = 0;
    for (int i = 0; i < N; i++) m_gr[i] = 0;
  endtask

  task automatic stats_chk();
`ifdef GATE_SHARE_ARBITER_STATS_EN
    chk("op_count", 32'(op_count), 32'(m_ops));
    for (int i = 0; i < N; i++)
      chk("grant_hist", 32'(grant_hist[i*8 +: 8]), 32'(m_gr[i]));
`endif
  endtask

  // Called in an IDLE cycle with inputs applied; returns in the next IDLE.
  task automatic txn(input int gi, input logic [7:0] ey,
                     input int stall, input bit keep);
    @(negedge clk);
    chk("grant", 32'(bus.req_ready), 32'(1) << gi);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("rv_idle", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
    if (!keep) v[gi] = 1'b0;
    scramble();
    bus.req_valid = v;
    m_gr[gi]++;
    ptr = (gi + 1) % N;
    @(negedge clk);
    chk("ready_exec", 32'(bus.req_ready), 32'd0);
    chk("busy_exec", 32'(busy), 32'd1);
    chk("rv_exec", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
    bus.resp_ready = (stall == 0);
    @(negedge clk);
    chk("rv_resp", 32'(bus.resp_valid), 32'd1);
    chk("resp_y", 32'(bus.resp_y), 32'(ey));
    chk("resp_id", 32'(bus.resp_id), 32'(gi));
    chk("ready_resp", 32'(bus.req_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      scramble();
      bus.resp_ready = (s == stall - 1);
      @(negedge clk);
      chk("rv_hold", 32'(bus.resp_valid), 32'd1);
      chk("y_hold", 32'(bus.resp_y), 32'(ey));
      chk("id_hold", 32'(bus.resp_id), 32'(gi));
      chk("ready_hold", 32'(bus.req_ready), 32'd0);
      chk("busy_hold", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    m_ops++;
    bus.resp_ready = 1'b1;
    drive();
    stats_chk();
  endtask

  initial begin
    int g;
    rst = 1'b1;
    v = 4'hF;
    for (int i = 0; i < N; i++) begin
      ra[i]  = 8'(8'h11 * (i + 1));
      rb[i]  = 8'(8'h3C + i);
      rop[i] = 2'(i);
    end
    bus.resp_ready = 1'b1;
    drive();
    clear_model();

    // Reset held two cycles with every requester asking.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rv", 32'(bus.resp_valid), 32'd0);
    chk("rst_y", 32'(bus.resp_y), 32'd0);
    chk("rst_id", 32'(bus.resp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    stats_chk();

    // All four held valid: strict rotation 0,1,2,3,0,1,2,3.
    for (int t = 0; t < 8; t++)
      txn(t % N, gate(rop[t % N], ra[t % N], rb[t % N]), 0, 1'b1);

    // Single NAND request on requester 0.
    v = 4'b0001;
    ra[0] = 8'hF0; rb[0] = 8'hCC; rop[0] = 2'b00;
    drive();
    txn(0, 8'h3F, 0, 1'b0);
    v = 4'b0000;
    drive();
    @(negedge clk);
    chk("busy_after", 32'(busy), 32'd0);
    chk("ready_none", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;

    // Every opcode on requester 2.
    ra[2] = 8'hA5; rb[2] = 8'h0F;
    rop[2] = 2'b01; v = 4'b0100; drive(); txn(2, 8'h05, 0, 1'b0);
    rop[2] = 2'b10; v = 4'b0100; drive(); txn(2, 8'h50, 0, 1'b0);
    rop[2] = 2'b11; v = 4'b0100; drive(); txn(2, 8'hAF, 0, 1'b0);
    rop[2] = 2'b00; v = 4'b0100; drive(); txn(2, 8'hFA, 0, 1'b0);

    // Backpressure for 5 cycles with everyone waiting, then next grant.
    v = 4'hF;
    for (int i = 0; i < N; i++) begin
      ra[i]  = 8'($urandom);
      rb[i]  = 8'($urandom);
      rop[i] = 2'($urandom);
    end
    drive();
    g = pick(v, ptr);
    txn(g, gate(rop[g], ra[g], rb[g]), 5, 1'b1);
    g = pick(v, ptr);
    txn(g, gate(rop[g], ra[g], rb[g]), 0, 1'b0);

    // Reset while executing: no response, pointer back to 0.
    v = 4'b0010;
    drive();
    @(negedge clk);
    chk("mid_grant", 32'(bus.req_ready), 32'b0010);
    @(posedge clk); #1;
    rst = 1'b1;
    v = 4'b0000;
    drive();
    @(negedge clk);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    chk("mid_rv", 32'(bus.resp_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_y", 32'(bus.resp_y), 32'd0);
    stats_chk();
    @(posedge clk); #1;
    v = 4'b1010;
    drive();
    g = pick(v, ptr);
    txn(g, gate(rop[g], ra[g], rb[g]), 0, 1'b0);

    // Random masks, operands, ops and stalls against the model.
    for (int it = 0; it < 60; it++) begin
      v = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        ra[i]  = 8'($urandom);
        rb[i]  = 8'($urandom);
        rop[i] = 2'($urandom);
      end
      drive();
      if (v == 4'b0000) begin
        @(negedge clk);
        chk("rand_idle_ready", 32'(bus.req_ready), 32'd0);
        chk("rand_idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
      end else begin
        g = pick(v, ptr);
        txn(g, gate(rop[g], ra[g], rb[g]),
            int'($urandom_range(0, 3)), 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
